// File: rtl/mvm_pingpong_ctrl.sv
// Matrix-vector multiply controller: weight load, then ping-pong X banks
// feeding a row-by-row MAC schedule with a valid/ready result port.
module mvm_pingpong_ctrl #(
  parameter int M = 3,
  parameter int N = 3,
  localparam int AW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int XW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  output logic          input_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [AW-1:0] addr_w,
  output logic          wr_en_w,
  output logic [XW-1:0] addr_x_wr,
  output logic          x_wr_bank,
  output logic          wr_en_x,
  output logic [XW-1:0] addr_x_rd,
  output logic          x_rd_bank,
  output logic          clear_acc,
  output logic          en_acc,
  output logic [RW-1:0] row_idx
);

  typedef enum logic {L_W, L_X} lst_t;
  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_MAC  = 2'd1,
    C_SEND = 2'd2
  } cst_t;

  lst_t          l_q;
  cst_t          c_q;
  logic [AW-1:0] wcnt_q;
  logic [XW-1:0] xcnt_q;
  logic          xwb_q;
  logic [RW-1:0] row_q;
  logic [XW-1:0] col_q;
  logic          xrb_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          first_q;

  logic          beat;
  logic          hs;
  logic          x_last;
  logic          v_last;
  logic [AW-1:0] mac_addr;

  assign input_ready = !rst && (l_q == L_W || !full_q[xwb_q]);
  assign beat        = input_valid && input_ready;
  assign wr_en_w     = beat && l_q == L_W;
  assign wr_en_x     = beat && l_q == L_X;
  assign output_valid = !rst && c_q == C_SEND;
  assign hs          = output_valid && output_ready;
  assign en_acc      = !rst && c_q == C_MAC;
  assign clear_acc   = rst || first_q || hs;
  assign x_last      = wr_en_x && xcnt_q == XW'(N - 1);
  assign v_last      = hs && row_q == RW'(M - 1);
  assign mac_addr    = AW'(int'(row_q) * N + int'(col_q));

  // Weights own the address bus until loaded, then compute drives it.
  assign addr_w    = rst ? '0 : (l_q == L_W ? wcnt_q : mac_addr);
  assign addr_x_wr = rst ? '0 : xcnt_q;
  assign x_wr_bank = !rst && xwb_q;
  assign addr_x_rd = rst ? '0 : col_q;
  assign x_rd_bank = !rst && xrb_q;
  assign row_idx   = rst ? '0 : row_q;

  // Set and clear never hit the same bank: a full bank refuses beats.
  always_comb begin
    full_d = full_q;
    if (x_last) full_d[xwb_q] = 1'b1;
    if (v_last) full_d[xrb_q] = 1'b0;
    if (rst) full_d = '0;
  end

  always_ff @(posedge clk) begin
    full_q  <= full_d;
    first_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q    <= L_W;
      wcnt_q <= '0;
      xcnt_q <= '0;
      xwb_q  <= 1'b0;
    end else if (l_q == L_W) begin
      if (beat) begin
        if (wcnt_q == AW'(M * N - 1)) l_q <= L_X;
        else wcnt_q <= wcnt_q + AW'(1);
      end
    end else if (beat) begin
      if (x_last) begin
        xcnt_q <= '0;
        xwb_q  <= ~xwb_q;
      end else begin
        xcnt_q <= xcnt_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= C_IDLE;
      row_q <= '0;
      col_q <= '0;
      xrb_q <= 1'b0;
    end else begin
      case (c_q)
        C_IDLE: begin
          row_q <= '0;
          col_q <= '0;
          if (l_q == L_X && full_q[xrb_q]) c_q <= C_MAC;
        end
        C_MAC: begin
          if (col_q == XW'(N - 1)) c_q <= C_SEND;
          else col_q <= col_q + XW'(1);
        end
        C_SEND: begin
          if (output_ready) begin
            if (row_q == RW'(M - 1)) begin
              c_q   <= C_IDLE;
              xrb_q <= ~xrb_q;
            end else begin
              row_q <= row_q + RW'(1);
              col_q <= '0;
              c_q   <= C_MAC;
            end
          end
        end
        default: begin
          c_q   <= C_IDLE;
          row_q <= '0;
          col_q <= '0;
          xrb_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_pingpong_ctrl.sv
// Scoreboard bench: RAMs and accumulator are modelled here, driven by the
// controller's strobes; expected rows come from plain matrix arithmetic.
module tb_mvm_pingpong_ctrl;
  localparam int M  = 3;
  localparam int N  = 3;
  localparam int AW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int XW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_valid;
  logic          input_ready;
  logic          output_valid;
  logic          output_ready;
  logic [AW-1:0] addr_w;
  logic          wr_en_w;
  logic [XW-1:0] addr_x_wr;
  logic          x_wr_bank;
  logic          wr_en_x;
  logic [XW-1:0] addr_x_rd;
  logic          x_rd_bank;
  logic          clear_acc;
  logic          en_acc;
  logic [RW-1:0] row_idx;

  mvm_pingpong_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready),
    .output_valid(output_valid), .output_ready(output_ready),
    .addr_w(addr_w), .wr_en_w(wr_en_w),
    .addr_x_wr(addr_x_wr), .x_wr_bank(x_wr_bank), .wr_en_x(wr_en_x),
    .addr_x_rd(addr_x_rd), .x_rd_bank(x_rd_bank),
    .clear_acc(clear_acc), .en_acc(en_acc), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int row;} res_t;

  int   checks = 0;
  int   errors = 0;
  int   wmodel[M*N];
  int   wram[M*N];
  int   xram[2][N];
  int   xmodel[N];
  int   beats_q[$];
  res_t exp_q[$];
  int   in_data = 0;
  int   wexp = 0, xc = 0, xb = 0, loaded = 0, done = 0;
  int   acc = 0, cyc = 0, last_hs = 0, prev_row = 0;
  bit   first_after = 0, prev_stall = 0, saw_row1 = 0, tput_chk = 0;
  int   vprob = 100, oprob = 100, stall_cnt = 0;
  bit   rnd_stall = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Input driver: beats from the queue, random valid gaps and ready stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      input_valid = beats_q.size() > 0 && $urandom_range(99) < vprob;
      in_data = beats_q.size() > 0 ? beats_q[0] : 0;
      if (stall_cnt > 0) begin
        output_ready = 1'b0;
        stall_cnt--;
      end else begin
        output_ready = $urandom_range(99) < oprob;
        if (rnd_stall && $urandom_range(99) < 3) stall_cnt = 12;
      end
    end
  end

  // Monitor: models the RAMs/accumulator and scores every result.
  initial begin
    bit   beat, fa;
    res_t e;
    int   s;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_outputs", {input_ready, output_valid, wr_en_w, wr_en_x,
            x_wr_bank, x_rd_bank, en_acc, addr_w, addr_x_wr, addr_x_rd,
            row_idx}, 0);
        chk("rst_clear_acc", clear_acc, 1);
        exp_q.delete();
        beats_q.delete();
        wexp = 0; xc = 0; xb = 0; loaded = 0; done = 0; acc = 0;
        prev_stall = 0; saw_row1 = 0; first_after = 1;
      end else begin
        fa = first_after;
        if (fa) chk("post_rst_clear", clear_acc, 1);
        first_after = 0;
        if (wexp < M * N) chk("ready_lw", input_ready, 1);
        else chk("ready_lx", input_ready, (loaded - done) < 2);
        beat = input_valid && input_ready;
        chk("wr_en_w", wr_en_w, beat && wexp < M * N);
        chk("wr_en_x", wr_en_x, beat && wexp == M * N);
        if (wr_en_w) wram[addr_w] = in_data;
        if (wr_en_x) xram[x_wr_bank][addr_x_wr] = in_data;
        if (beat && beats_q.size() > 0) begin
          if (wexp < M * N) begin
            chk("addr_w_load", addr_w, wexp);
            wmodel[wexp] = in_data;
            wexp++;
          end else begin
            chk("addr_x_wr", addr_x_wr, xc);
            chk("x_wr_bank", x_wr_bank, xb);
            xmodel[xc] = in_data;
            xc++;
            if (xc == N) begin
              xc = 0; xb ^= 1; loaded++;
              for (int r = 0; r < M; r++) begin
                s = 0;
                for (int c = 0; c < N; c++) s += wmodel[r*N+c] * xmodel[c];
                exp_q.push_back('{val: s, row: r});
              end
            end
          end
          void'(beats_q.pop_front());
        end
        if (en_acc) chk("en_acc_weights_loaded", wexp, M * N);
        if (output_valid) chk("en_acc_in_send", en_acc, 0);
        if (prev_stall) begin
          chk("stall_valid", output_valid, 1);
          chk("stall_row", row_idx, prev_row);
        end
        if (output_valid && output_ready) begin
          chk("pending_results", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", acc, e.val);
            chk("row_idx", row_idx, e.row);
            chk("clear_on_hs", clear_acc, 1);
            if (tput_chk && e.row > 0) chk("row_gap", cyc - last_hs, N + 1);
            if (e.row == M - 1) done++;
          end
          last_hs = cyc;
        end else if (!fa) begin
          chk("no_clear", clear_acc, 0);
        end
        if (en_acc && row_idx == 1) saw_row1 = 1;
        if (clear_acc) acc = 0;
        else if (en_acc) acc += wram[addr_w] * xram[x_rd_bank][addr_x_rd];
        prev_stall = output_valid && !output_ready;
        prev_row = row_idx;
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_weights(input bit ident);
    for (int i = 0; i < M * N; i++)
      beats_q.push_back(ident ? int'(i / N == i % N) : int'($urandom_range(255)));
  endtask

  task automatic push_vecs(input int n);
    for (int i = 0; i < n * N; i++) beats_q.push_back(int'($urandom_range(255)));
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done < target && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("vectors_done", done, target);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    input_valid = 1'b0;
    output_ready = 1'b0;
    do_reset(3);

    tput_chk = 1;
    push_weights(1);
    beats_q.push_back(5);
    beats_q.push_back(7);
    beats_q.push_back(9);
    push_vecs(2);
    wait_done(3);
    tput_chk = 0;

    do_reset(2);
    vprob = 60; oprob = 70; rnd_stall = 1;
    push_weights(0);
    push_vecs(6);
    wait_done(6);

    rnd_stall = 0; oprob = 100; vprob = 100;
    do_reset(2);
    push_weights(0);
    push_vecs(1);
    k = 0;
    while (!saw_row1 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("reached_row1_mac", saw_row1, 1);
    do_reset(1);
    vprob = 50;
    push_weights(0);
    push_vecs(2);
    wait_done(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
